capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl_pkg.sv | 26 ++
 rtl/capture_ctrl_if.sv | 25 ++
 rtl/capture_ctrl_cnt.sv | 25 ++
 rtl/capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_capture_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_ctrl_pkg.sv
// Shared types and constants for the capture controller: FSM states, count-command
// field positions and the count scale applied to command fields.
package logip_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMD,
      DLY,
      FETCH,
      SEND
   } capt_state_t;

   localparam int CNT_W       = 18;
   localparam int CNT_SCALE   = 4;
   localparam int CMD_FLD_W   = 16;
   localparam int CMD_RD_LSB  = 0;
   localparam int CMD_RD_MSB  = 15;
   localparam int CMD_DLY_LSB = 16;
   localparam int CMD_DLY_MSB = 31;

   // Counts are kept as (count - 1): (field+1)*4 - 1 = field*4 + 3 always fits CNT_W bits.
   function automatic logic [CNT_W-1:0] cnt_m1(input logic [CMD_FLD_W-1:0] fld);
      return CNT_W'(fld) * CNT_W'(CNT_SCALE) + CNT_W'(CNT_SCALE - 1);
   endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Memory port and readout stream of the capture controller, grouped as one bus.
// The master side is the controller; the slave side is the sample memory plus downstream sink.
interface capture_ctrl_if #(
   parameter int CHLS = 32,
   parameter int AW   = 12
);
   logic            we_o;
   logic [AW-1:0]   waddr_o;
   logic [CHLS-1:0] wdata_o;
   logic [AW-1:0]   raddr_o;
   logic [CHLS-1:0] rdata_i;
   logic            tx_vld_o;
   logic [CHLS-1:0] tx_data_o;
   logic            tx_rdy_i;

   modport master (
      output we_o, waddr_o, wdata_o, raddr_o, tx_vld_o, tx_data_o,
      input  rdata_i, tx_rdy_i
   );

   modport slave (
      input  we_o, waddr_o, wdata_o, raddr_o, tx_vld_o, tx_data_o,
      output rdata_i, tx_rdy_i
   );
endinterface

// File: rtl/capture_ctrl_cnt.sv
// capt_cnt: loadable down-counter with a zero flag; saturates at zero.
module capt_cnt #(
   parameter int W = 18
) (
   input  logic         clk_i,
   input  logic         rst_in,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         cnt_reg <= '0;
      end else if (load_i) begin
         cnt_reg <= load_val_i;
      end else if (dec_i && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero_o = (cnt_reg == '0);
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger sample capture into a ring memory, then newest-first readout.
// Define LOGIP_CAPT_CLAMP_EN to clamp the latched read and delay counts to DEPTH.
module capture_ctrl
   import logip_pkg::*;
#(
   parameter int CHLS  = 32,
   parameter int DEPTH = 4096
) (
   input  logic              clk_i,
   input  logic              rst_in,
   input  logic [31:0]       cmd_i,
   input  logic              set_cnt_i,
   input  logic              arm_i,
   input  logic              run_i,
   input  logic              stb_i,
   input  logic [CHLS-1:0]   smpls_i,
   output logic              busy_o,
   capture_ctrl_if.master    bus
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CI_DLY = 0;
   localparam int CI_RD  = 1;

   capt_state_t      state_reg, state_next;
   logic [AW-1:0]    wptr_reg, wptr_next;
   logic [AW-1:0]    rptr_reg, rptr_next;
   logic [CNT_W-1:0] rd_m1_reg, rd_m1_next;
   logic [CNT_W-1:0] dly_m1_reg, dly_m1_next;
   logic             wr_en;
   logic [1:0]       cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val [2];

   function automatic logic [CNT_W-1:0] clamp_m1(input logic [CNT_W-1:0] m1);
`ifdef LOGIP_CAPT_CLAMP_EN
      if (m1 > CNT_W'(DEPTH - 1)) begin
         return CNT_W'(DEPTH - 1);
      end
`endif
      return m1;
   endfunction

   // Both counters hold "remaining - 1" so the zero flag marks the final sample/word.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         capt_cnt #(.W(CNT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_in     (rst_in),
            .load_i     (cnt_load[gi]),
            .load_val_i (cnt_val[gi]),
            .dec_i      (cnt_dec[gi]),
            .zero_o     (cnt_zero[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      wptr_next   = wptr_reg;
      rptr_next   = rptr_reg;
      rd_m1_next  = rd_m1_reg;
      dly_m1_next = dly_m1_reg;
      wr_en       = 1'b0;
      cnt_load    = '0;
      cnt_dec     = '0;
      cnt_val[0]  = '0;
      cnt_val[1]  = '0;

      case (state_reg)
         IDLE: begin
            if (set_cnt_i) begin
               rd_m1_next  = clamp_m1(cnt_m1(cmd_i[CMD_RD_MSB:CMD_RD_LSB]));
               dly_m1_next = clamp_m1(cnt_m1(cmd_i[CMD_DLY_MSB:CMD_DLY_LSB]));
            end
            if (arm_i) begin
               state_next = ARMD;
            end
         end
         ARMD: begin
            wr_en = stb_i;
            if (run_i) begin
               state_next       = DLY;
               cnt_load[CI_DLY] = 1'b1;
               // A strobe coinciding with the trigger is already the first delay sample.
               cnt_val[CI_DLY]  = stb_i ? (dly_m1_reg - CNT_W'(1)) : dly_m1_reg;
            end
         end
         DLY: begin
            wr_en = stb_i;
            if (stb_i) begin
               if (cnt_zero[CI_DLY]) begin
                  state_next      = FETCH;
                  rptr_next       = wptr_reg;
                  cnt_load[CI_RD] = 1'b1;
                  cnt_val[CI_RD]  = rd_m1_reg;
               end else begin
                  cnt_dec[CI_DLY] = 1'b1;
               end
            end
         end
         FETCH: begin
            state_next = SEND;
         end
         SEND: begin
            if (bus.tx_rdy_i) begin
               if (cnt_zero[CI_RD]) begin
                  state_next = IDLE;
               end else begin
                  state_next     = FETCH;
                  cnt_dec[CI_RD] = 1'b1;
                  rptr_next      = rptr_reg - AW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (wr_en) begin
         wptr_next = wptr_reg + AW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_reg  <= IDLE;
         wptr_reg   <= '0;
         rptr_reg   <= '0;
         rd_m1_reg  <= CNT_W'(CNT_SCALE - 1);
         dly_m1_reg <= CNT_W'(CNT_SCALE - 1);
      end else begin
         state_reg  <= state_next;
         wptr_reg   <= wptr_next;
         rptr_reg   <= rptr_next;
         rd_m1_reg  <= rd_m1_next;
         dly_m1_reg <= dly_m1_next;
      end
   end

   // raddr_o stays put throughout SEND, so the registered read data is stable there.
   assign bus.we_o      = wr_en;
   assign bus.waddr_o   = wptr_reg;
   assign bus.wdata_o   = smpls_i;
   assign bus.raddr_o   = rptr_reg;
   assign bus.tx_vld_o  = (state_reg == SEND);
   assign bus.tx_data_o = bus.rdata_i;
   assign busy_o        = (state_reg != IDLE);
endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized self-checking bench for capture_ctrl against a ring-buffer reference model.
module tb_capture_ctrl;
   localparam int CHLS  = 32;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic            clk_i = 1'b0;
   logic            rst_in = 1'b0;
   logic [31:0]     cmd_i = '0;
   logic            set_cnt_i = 1'b0;
   logic            arm_i = 1'b0;
   logic            run_i = 1'b0;
   logic            stb_i = 1'b0;
   logic [CHLS-1:0] smpls_i = '0;
   logic            busy_o;

   capture_ctrl_if #(.CHLS(CHLS), .AW(AW)) bus ();

   capture_ctrl #(.CHLS(CHLS), .DEPTH(DEPTH)) dut (
      .clk_i     (clk_i),
      .rst_in    (rst_in),
      .cmd_i     (cmd_i),
      .set_cnt_i (set_cnt_i),
      .arm_i     (arm_i),
      .run_i     (run_i),
      .stb_i     (stb_i),
      .smpls_i   (smpls_i),
      .busy_o    (busy_o),
      .bus       (bus)
   );

   always #5 clk_i = ~clk_i;

   // Sample memory with one-cycle registered read
   logic [CHLS-1:0] mem [DEPTH];
   always @(posedge clk_i) begin
      if (bus.we_o) mem[bus.waddr_o] <= bus.wdata_o;
      bus.rdata_i <= mem[bus.raddr_o];
   end

   // Reference model: what each address should hold, where the newest sample went, latched counts
   logic [CHLS-1:0] mdl_mem [DEPTH];
   int mdl_wptr, mdl_last, mdl_rd, mdl_dly;
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      set_cnt_i = 1'b0;
      arm_i = 1'b0;
      run_i = 1'b0;
      stb_i = 1'b0;
      bus.tx_rdy_i = 1'b0;
   endtask

   task automatic model_reset();
      mdl_wptr = 0;
      mdl_last = 0;
      mdl_rd   = 4;
      mdl_dly  = 4;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_in = 1'b0;
      next_cycle();
      stb_i = 1'b1;
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_we", bus.we_o, 0);
      check("rst_vld", bus.tx_vld_o, 0);
      check("rst_waddr", bus.waddr_o, 0);
      check("rst_raddr", bus.raddr_o, 0);
      stb_i = 1'b0;
      next_cycle();
      rst_in = 1'b1;
      model_reset();
      next_cycle();
   endtask

   // One capture-phase cycle: drive a strobe, compare the write port with the model
   task automatic capt_cycle(input bit stb, output bit wrote);
      stb_i = stb;
      smpls_i = $urandom;
      #1;
      check("we", bus.we_o, stb);
      check("busy", busy_o, 1);
      wrote = bus.we_o;
      if (stb) begin
         check("waddr", bus.waddr_o, mdl_wptr);
         check("wdata", bus.wdata_o, smpls_i);
         mdl_mem[mdl_wptr] = smpls_i;
         mdl_last = mdl_wptr;
         mdl_wptr = (mdl_wptr + 1) % DEPTH;
      end
      next_cycle();
   endtask

   task automatic run_capture(input string name, input bit do_set, input logic [31:0] cmd,
                              input int n_pre, input bit run_stb, input int stb_pct, input bit hold5);
      int got, dly_left, dly_writes, words, budget, hold, addr;
      bit stb, wrote, exp_vld, hs;

      if (do_set) begin
         cmd_i = cmd;
         set_cnt_i = 1'b1;
         run_i = 1'b1;
         stb_i = 1'b1;
         #1;
         check("idle_we", bus.we_o, 0);
         check("idle_busy", busy_o, 0);
         next_cycle();
         mdl_rd  = (int'(cmd[15:0]) + 1) * 4;
         mdl_dly = (int'(cmd[31:16]) + 1) * 4;
`ifdef LOGIP_CAPT_CLAMP_EN
         if (mdl_rd > DEPTH) mdl_rd = DEPTH;
         if (mdl_dly > DEPTH) mdl_dly = DEPTH;
`endif
      end
      clear_inputs();

      arm_i = 1'b1;
      stb_i = 1'b1;
      #1;
      check("arm_we", bus.we_o, 0);
      next_cycle();
      clear_inputs();

      got = 0;
      while (got < n_pre) begin
         stb = ($urandom_range(0, 99) < stb_pct);
         set_cnt_i = 1'($urandom_range(0, 1));
         arm_i = 1'($urandom_range(0, 1));
         cmd_i = $urandom;
         capt_cycle(stb, wrote);
         if (stb) got++;
      end
      clear_inputs();

      run_i = 1'b1;
      capt_cycle(run_stb, wrote);
      dly_writes = int'(wrote);
      dly_left = mdl_dly - int'(run_stb);
      while (dly_left > 0) begin
         stb = ($urandom_range(0, 99) < stb_pct);
         run_i = 1'($urandom_range(0, 1));
         set_cnt_i = 1'($urandom_range(0, 1));
         cmd_i = $urandom;
         capt_cycle(stb, wrote);
         if (stb) dly_left--;
         dly_writes += int'(wrote);
      end
      check("dly_writes", dly_writes, mdl_dly);

      words = 0;
      budget = 0;
      exp_vld = 1'b0;
      hold = hold5 ? 5 : 0;
      while (words < mdl_rd && budget < 4000) begin
         stb_i = 1'($urandom_range(0, 1));
         smpls_i = $urandom;
         run_i = 1'($urandom_range(0, 1));
         arm_i = 1'($urandom_range(0, 1));
         set_cnt_i = 1'($urandom_range(0, 1));
         cmd_i = $urandom;
         if (exp_vld && hold > 0) begin
            bus.tx_rdy_i = 1'b0;
            hold--;
         end else begin
            bus.tx_rdy_i = 1'($urandom_range(0, 1));
         end
         #1;
         check("rd_we", bus.we_o, 0);
         check("rd_busy", busy_o, 1);
         check("tx_vld", bus.tx_vld_o, exp_vld);
         hs = 1'b0;
         if (exp_vld) begin
            addr = (((mdl_last - words) % DEPTH) + DEPTH) % DEPTH;
            check("raddr", bus.raddr_o, addr);
            check("tx_data", bus.tx_data_o, mdl_mem[addr]);
            hs = bus.tx_rdy_i;
            if (hs) words++;
         end
         exp_vld = !hs;
         budget++;
         next_cycle();
      end
      check("rd_words", words, mdl_rd);
      clear_inputs();
      #1;
      check("end_busy", busy_o, 0);
      check("end_vld", bus.tx_vld_o, 0);
      $display("txn %s: rd=%0d dly=%0d newest=%0d words=%0d", name, mdl_rd, mdl_dly, mdl_last, words);
   endtask

   task automatic reset_mid_dly();
      bit wrote;
      do_reset();
      cmd_i = 32'h0003_0000;
      set_cnt_i = 1'b1;
      next_cycle();
      clear_inputs();
      arm_i = 1'b1;
      next_cycle();
      clear_inputs();
      for (int i = 0; i < 3; i++) capt_cycle(1'b1, wrote);
      run_i = 1'b1;
      capt_cycle(1'b1, wrote);
      run_i = 1'b0;
      for (int i = 0; i < 2; i++) capt_cycle(1'b1, wrote);
      stb_i = 1'b1;
      #1;
      check("pre_rst_we", bus.we_o, 1);
      rst_in = 1'b0;
      #1;
      check("mid_rst_we", bus.we_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_vld", bus.tx_vld_o, 0);
      check("mid_rst_waddr", bus.waddr_o, 0);
      next_cycle();
      rst_in = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         stb_i = 1'b1;
         run_i = 1'b1;
         #1;
         check("post_rst_we", bus.we_o, 0);
         check("post_rst_busy", busy_o, 0);
         next_cycle();
      end
      clear_inputs();
      $display("txn t5: reset asserted mid-delay");
      run_capture("t5_defaults", 1'b0, 32'h0, 6, 1'b0, 70, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c;
      clear_inputs();
      model_reset();
      do_reset();
      run_capture("t1", 1'b1, 32'h0000_0000, 10, 1'b0, 100, 1'b0);
      do_reset();
      run_capture("t2", 1'b1, 32'h0000_0002, 20, 1'b0, 100, 1'b0);
      do_reset();
      run_capture("t3", 1'b1, 32'h0000_0000, 5, 1'b1, 60, 1'b0);
      run_capture("t4", 1'b1, 32'h0000_0001, 3, 1'b0, 70, 1'b1);
      reset_mid_dly();
      run_capture("t6", 1'b1, 32'h0000_0007, 16, 1'b0, 80, 1'b0);
      for (int i = 0; i < 6; i++) begin
         c = '0;
         c[31:16] = 16'($urandom_range(0, 3));
         c[15:0]  = 16'($urandom_range(0, 5));
         run_capture("rnd", 1'b1, c, $urandom_range(0, 25), 1'($urandom_range(0, 1)),
                     $urandom_range(40, 100), 1'($urandom_range(0, 1)));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
